// File: rtl/abba_string_gen.sv
// Transmitter for the 2-bit symbol-string link: emits A B B A (REPS times) over a valid/ready handshake.
// Optional ABBA_GEN_PAD_EN inserts one C pad symbol after every final A of a repetition.
module abba_string_gen #(
    parameter int REPS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       ready,
    output logic [1:2] x,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    localparam logic [1:2] SYM_A = 2'b00;
    localparam logic [1:2] SYM_B = 2'b01;
    localparam logic [1:2] SYM_C = 2'b11;
    localparam logic [3:0] LAST_REP = 4'(REPS - 1);

`ifdef ABBA_GEN_PAD_EN
    typedef enum logic [2:0] {IDLE, S_A1, S_B1, S_B2, S_A2, S_PAD} state_t;
`else
    typedef enum logic [2:0] {IDLE, S_A1, S_B1, S_B2, S_A2} state_t;
`endif

    state_t     state, state_n;
    logic [3:0] rep_cnt, rep_cnt_n;
    logic [1:2] x_n;
    logic       valid_n;
    logic       done_n;
    logic       xfer;

    // valid is a register, so the transfer condition never feeds back into itself
    assign xfer = valid && ready;

    always_comb begin
        state_n   = state;
        rep_cnt_n = rep_cnt;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = S_A1;
                    rep_cnt_n = 4'd0;
                end
            end
            S_A1: if (xfer) state_n = S_B1;
            S_B1: if (xfer) state_n = S_B2;
            S_B2: if (xfer) state_n = S_A2;
`ifdef ABBA_GEN_PAD_EN
            S_A2: if (xfer) state_n = S_PAD;
            S_PAD: begin
`else
            S_A2: begin
`endif
                if (xfer) begin
                    if (rep_cnt == LAST_REP) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        rep_cnt_n = rep_cnt + 4'd1;
                        state_n   = S_A1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it
    always_comb begin
        x_n     = SYM_C;
        valid_n = 1'b1;
        case (state_n)
            IDLE:       valid_n = 1'b0;
            S_A1, S_A2: x_n = SYM_A;
            S_B1, S_B2: x_n = SYM_B;
            default:    x_n = SYM_C;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rep_cnt <= 4'd0;
            x       <= SYM_C;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            rep_cnt <= rep_cnt_n;
            x       <= x_n;
            valid   <= valid_n;
            busy    <= valid_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_abba_string_gen.sv
// Bench for abba_string_gen: REPS=1 and REPS=3 instances share stimulus; a symbol-queue model
// checks both every cycle, plus a vector table and hand-written corner sequences.
module tb_abba_string_gen;

`ifdef ABBA_GEN_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    logic clock = 1'b0;
    logic reset, start, ready;
    logic [1:2] x1, x3;
    logic v1, b1, d1, v3, b3, d3;

    always #5 clock = ~clock;

    abba_string_gen #(.REPS(1)) dut1 (.clock(clock), .reset(reset), .start(start), .ready(ready),
                                      .x(x1), .valid(v1), .busy(b1), .done(d1));
    abba_string_gen #(.REPS(3)) dut3 (.clock(clock), .reset(reset), .start(start), .ready(ready),
                                      .x(x3), .valid(v3), .busy(b3), .done(d3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a string is the list of symbols still owed to the sink
    int         len[2];
    int         pos[2];
    logic       mdone[2];
    logic [1:0] sym[2][64];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            len[i] = 0; pos[i] = 0; mdone[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input logic s, input logic r);
        int reps;
        reps = (i == 0) ? 1 : 3;
        mdone[i] = 1'b0;
        if (pos[i] < len[i]) begin
            if (r) begin
                pos[i]++;
                if (pos[i] == len[i]) mdone[i] = 1'b1;
            end
        end else if (s) begin
            len[i] = 0; pos[i] = 0;
            for (int k = 0; k < reps; k++) begin
                sym[i][len[i]++] = 2'b00; sym[i][len[i]++] = 2'b01;
                sym[i][len[i]++] = 2'b01; sym[i][len[i]++] = 2'b00;
                if (PAD == 1) sym[i][len[i]++] = 2'b11;
            end
        end
    endtask

    task automatic cmp_models();
        for (int i = 0; i < 2; i++) begin
            logic       eb;
            logic [1:0] ex;
            eb = pos[i] < len[i];
            ex = eb ? sym[i][pos[i]] : 2'b11;
            chk($sformatf("m%0d_x", i), int'(i == 0 ? x1 : x3), int'(ex));
            chk($sformatf("m%0d_valid", i), int'(i == 0 ? v1 : v3), int'(eb));
            chk($sformatf("m%0d_busy", i), int'(i == 0 ? b1 : b3), int'(eb));
            chk($sformatf("m%0d_done", i), int'(i == 0 ? d1 : d3), int'(mdone[i]));
        end
    endtask

    // Recogniser on the REPS=3 stream: z whenever the last four accepted symbols are A B B A
    logic [7:0] win;
    int zcnt, xfer3;

    // Called at a negedge: drive, clock, update model, compare at the next negedge
    task automatic cycle(input logic s, input logic r);
        logic       xf;
        logic [1:2] xs;
        start = s; ready = r;
        xf = v3 && r;
        xs = x3;
        @(posedge clock);
        model_step(0, s, r);
        model_step(1, s, r);
        if (xf) begin
            xfer3++;
            win = {win[5:0], xs};
            if (win == 8'b00_01_01_00) zcnt++;
        end
        @(negedge clock);
        cmp_models();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((b1 || b3) && n < 60) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        chk("drain_busy1", int'(b1), 0);
        chk("drain_busy3", int'(b3), 0);
        cycle(1'b0, 1'b0);
    endtask

    typedef struct {
        logic       s, r;
        logic [1:0] x;
        logic       v, b, d;
    } vec_t;
    vec_t tv[$];

    function automatic void add(input logic s, r, input logic [1:0] xe, input logic v, b, d);
        tv.push_back('{s, r, xe, v, b, d});
    endfunction

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; ready = 1'b0;
        win = 8'hFF; zcnt = 0; xfer3 = 0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_x", int'(x1), 3);
        chk("rst_valid", int'(v1), 0);
        reset = 1'b0;

        // idle hold, single string at ready=1, then the stalled ready pattern
        repeat (5) add(0, 0, 2'b11, 0, 0, 0);
        add(1, 1, 2'b00, 1, 1, 0);
        add(0, 1, 2'b01, 1, 1, 0);
        add(0, 1, 2'b01, 1, 1, 0);
        add(0, 1, 2'b00, 1, 1, 0);
`ifdef ABBA_GEN_PAD_EN
        add(0, 1, 2'b11, 1, 1, 0);
`endif
        add(0, 1, 2'b11, 0, 0, 1);
        add(0, 0, 2'b11, 0, 0, 0);
        add(1, 0, 2'b00, 1, 1, 0);
        add(0, 1, 2'b01, 1, 1, 0);
        add(0, 0, 2'b01, 1, 1, 0);
        add(0, 0, 2'b01, 1, 1, 0);
        add(0, 1, 2'b01, 1, 1, 0);
        add(0, 0, 2'b01, 1, 1, 0);
        add(0, 1, 2'b00, 1, 1, 0);
`ifdef ABBA_GEN_PAD_EN
        add(0, 1, 2'b11, 1, 1, 0);
`endif
        add(0, 1, 2'b11, 0, 0, 1);
        add(0, 0, 2'b11, 0, 0, 0);
        for (int k = 0; k < tv.size(); k++) begin
            cycle(tv[k].s, tv[k].r);
            chk($sformatf("vec%0d_x", k), int'(x1), int'(tv[k].x));
            chk($sformatf("vec%0d_valid", k), int'(v1), int'(tv[k].v));
            chk($sformatf("vec%0d_busy", k), int'(b1), int'(tv[k].b));
            chk($sformatf("vec%0d_done", k), int'(d1), int'(tv[k].d));
        end
        drain();

        // REPS=3 at ready=1: length, symbol count and recogniser hits
        win = 8'hFF; zcnt = 0; xfer3 = 0;
        cycle(1'b1, 1'b1);
        n = 1;
        while (!d3 && n < 60) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        chk("reps3_cycles", n, (4 + PAD) * 3 + 1);
        chk("reps3_symbols", xfer3, (4 + PAD) * 3);
        chk("reps3_z", zcnt, 3);
        drain();

        // start while busy is ignored; async reset mid-string; fresh start afterwards
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        chk("busy_start_x", int'(x1), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_x1", int'(x1), 3);
        chk("async_rst_v1", int'(v1), 0);
        chk("async_rst_x3", int'(x3), 3);
        chk("async_rst_b3", int'(b3), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("restart_x", int'(x1), 0);
        chk("restart_valid", int'(v1), 1);
        drain();

        // start in the done cycle begins the next string immediately
        cycle(1'b1, 1'b1);
        n = 0;
        while (!d1 && n < 20) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        chk("done_seen", int'(d1), 1);
        cycle(1'b1, 1'b1);
        chk("b2b_x", int'(x1), 0);
        chk("b2b_valid", int'(v1), 1);
        drain();

        // randomized traffic against the model
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
